// File: rtl/invshiftrowsstep_if.sv
// Step interface shared by the ShiftRows/InvShiftRows round steps.
// The master drives the request, and the slave returns the registered result.
interface invshiftrowsstep_if;
    logic         start;
    logic [127:0] in;
    logic [127:0] key;
    logic         finish;
    logic [127:0] invshiftrowsstep;

    modport master (output start, in, key, input finish, invshiftrowsstep);
    modport slave  (input start, in, key, output finish, invshiftrowsstep);
endinterface

// File: rtl/invshiftrowsstep.sv
// AES InvShiftRows step: right-rotates row r of the state by r bytes, one row per clock.
// Define INVSHIFTROWS_PARALLEL_EN to rotate all rows in a single cycle instead.
//
// state | meaning
// IDLE  | waiting for start, finish low
// ROWS  | rotating rows of work (abort on start low)
// DONE  | result valid, waiting for start to drop
module invshiftrowsstep (
    input  logic               clk,
    input  logic               rst,
    invshiftrowsstep_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ROWS = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]   state;
    logic [127:0] work;
    logic [127:0] result;
    logic         finish;
`ifndef INVSHIFTROWS_PARALLEL_EN
    logic [1:0]   row;
`endif

    // Byte r+4c of the result takes byte r+4((c-r) mod 4); other rows pass through.
    function automatic logic [127:0] rot_row(input logic [127:0] s, input logic [1:0] r);
        logic [127:0] o;
        int           ri;
        o  = s;
        ri = int'(r);
        for (int c = 0; c < 4; c++) begin
            o[8*(ri + 4*c) +: 8] = s[8*(ri + 4*((c - ri) & 3)) +: 8];
        end
        return o;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            work   <= '0;
            result <= '0;
            finish <= 1'b0;
`ifndef INVSHIFTROWS_PARALLEL_EN
            row    <= 2'd0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    finish <= 1'b0;
                    if (bus.start) begin
                        work  <= bus.in;
                        state <= S_ROWS;
`ifndef INVSHIFTROWS_PARALLEL_EN
                        row   <= 2'd1;
`endif
                    end
                end
                S_ROWS: begin
                    // An abort wins over completion; output and finish keep their values.
                    if (!bus.start) begin
                        state <= S_IDLE;
                    end else begin
`ifdef INVSHIFTROWS_PARALLEL_EN
                        result <= rot_row(rot_row(rot_row(work, 2'd1), 2'd2), 2'd3);
                        finish <= 1'b1;
                        state  <= S_DONE;
`else
                        if (row == 2'd3) begin
                            result <= rot_row(work, row);
                            finish <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            work <= rot_row(work, row);
                            row  <= row + 2'd1;
                        end
`endif
                    end
                end
                S_DONE: begin
                    if (!bus.start) begin
                        finish <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    finish <= 1'b0;
                end
            endcase
        end
    end

    assign bus.finish           = finish;
    assign bus.invshiftrowsstep = result;
endmodule

// File: tb/tb_invshiftrowsstep.sv
// Self-checking bench for invshiftrowsstep: table vectors, handshake corner cases
// and random states checked against a queue-based row-rotation model.
module tb_invshiftrowsstep;
    logic clk;
    logic rst;

    invshiftrowsstep_if bus ();

    invshiftrowsstep dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef INVSHIFTROWS_PARALLEL_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 4;
`endif

    typedef struct {
        logic [127:0] in;
        logic [127:0] key;
        logic [127:0] exp;
    } vec_t;

    int n_vec;
    int n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: collect each row into a queue and rotate it right row-index times.
    function automatic logic [127:0] ref_inv(input logic [127:0] s);
        logic [7:0]   q[$];
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            q.delete();
            for (int c = 0; c < 4; c++) q.push_back(s[8*(r+4*c) +: 8]);
            for (int k = 0; k < r; k++) q.push_front(q.pop_back());
            for (int c = 0; c < 4; c++) o[8*(r+4*c) +: 8] = q[c];
        end
        return o;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Raise start and wait for finish; leaves start high (result in DONE).
    task automatic start_and_wait(input string name, input logic [127:0] din,
                                  input logic [127:0] dkey, input logic [127:0] exp);
        int cyc;
        @(negedge clk);
        bus.start = 1'b1;
        bus.in    = din;
        bus.key   = dkey;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (bus.finish !== 1'b1 && cyc < 20);
        chk({name, "_latency"}, 128'(cyc), 128'(LAT));
        chk({name, "_out"}, bus.invshiftrowsstep, exp);
    endtask

    task automatic drop_start(input string name);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        chk({name, "_finish_fall"}, 128'(bus.finish), 128'(0));
    endtask

    task automatic run_op(input string name, input logic [127:0] din,
                          input logic [127:0] dkey, input logic [127:0] exp);
        start_and_wait(name, din, dkey, exp);
        drop_start(name);
    endtask

    vec_t         tbl[4];
    logic [127:0] a, b, prev, exp;

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.in    = '0;
        bus.key   = '0;

        tbl[0] = '{128'h119fc17396be93e9e2173d2e2a7e406b, 128'h3c4fcf098815f7aba6d2ae2816157e2b,
                   128'h2a179373117e3de9969f402ee2bec16b};
        tbl[1] = '{128'hacac2d459c8aaf9e578eb71e516f03ae, 128'h0,
                   128'h518eaf45ac6fb79e9cac031e578a2dae};
        tbl[2] = '{128'h19e4c81a111c0ae54652fba3efc15c30, 128'h0,
                   128'hef520a1a19c1fbe511e45ca3461cc830};
        tbl[3] = '{128'h7b9b9fe617246cad45372bdf10414ff6, 128'h0,
                   128'h10376ce67b412bad179b4fdf45249ff6};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_finish", 128'(bus.finish), 128'(0));
        chk("reset_out", bus.invshiftrowsstep, 128'h0);
        @(negedge clk);
        rst = 1'b0;

        // Spec vectors back to back; model cross-checked against each table entry.
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("model_tbl%0d", i), ref_inv(tbl[i].in), tbl[i].exp);
            run_op($sformatf("tbl%0d", i), tbl[i].in, tbl[i].key, tbl[i].exp);
        end

        // Input and key changed right after capture.
        a = rnd128();
        @(negedge clk);
        bus.start = 1'b1;
        bus.in    = a;
        bus.key   = rnd128();
        @(negedge clk);
        bus.in    = rnd128();
        bus.key   = rnd128();
        begin
            int cyc;
            cyc = 1;
            do begin
                @(posedge clk);
                #1;
                cyc++;
            end while (bus.finish !== 1'b1 && cyc < 20);
            chk("late_in_latency", 128'(cyc), 128'(LAT));
            chk("late_in_out", bus.invshiftrowsstep, ref_inv(a));
        end
        drop_start("late_in");
        prev = ref_inv(a);

        // Aborts: right after capture, and on the edge where finish would rise.
        for (int ab = 1; ab <= LAT - 1; ab += (LAT > 2) ? LAT - 2 : 1) begin
            @(negedge clk);
            bus.start = 1'b1;
            bus.in    = rnd128();
            repeat (ab) @(negedge clk);
            bus.start = 1'b0;
            for (int k = 0; k < 3; k++) begin
                @(posedge clk);
                #1;
                chk($sformatf("abort%0d_finish", ab), 128'(bus.finish), 128'(0));
                chk($sformatf("abort%0d_out", ab), bus.invshiftrowsstep, prev);
            end
            b = rnd128();
            run_op($sformatf("after_abort%0d", ab), b, rnd128(), ref_inv(b));
            prev = ref_inv(b);
        end

        // Reset during ROWS.
        @(negedge clk);
        bus.start = 1'b1;
        bus.in    = rnd128();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_rows_finish", 128'(bus.finish), 128'(0));
        chk("rst_rows_out", bus.invshiftrowsstep, 128'h0);
        @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b0;
        a = rnd128();
        run_op("after_rst_rows", a, rnd128(), ref_inv(a));

        // Reset during DONE.
        a = rnd128();
        start_and_wait("pre_rst_done", a, rnd128(), ref_inv(a));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_done_finish", 128'(bus.finish), 128'(0));
        chk("rst_done_out", bus.invshiftrowsstep, 128'h0);
        @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b0;
        a = rnd128();
        run_op("after_rst_done", a, rnd128(), ref_inv(a));

        // Hold start in DONE with a new input: no restart.
        a = rnd128();
        start_and_wait("hold", a, rnd128(), ref_inv(a));
        exp = ref_inv(a);
        @(negedge clk);
        bus.in = rnd128();
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            chk("hold_finish", 128'(bus.finish), 128'(1));
            chk("hold_out", bus.invshiftrowsstep, exp);
        end
        drop_start("hold");

        // Random states against the model.
        for (int i = 0; i < 25; i++) begin
            a = rnd128();
            run_op($sformatf("rand%0d", i), a, rnd128(), ref_inv(a));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/invshiftrowsstep.md
# invshiftrowsstep

Inverse of the AES ShiftRows step, used on the decryption datapath. It rotates rows 1–3 of the 128-bit state right by 1/2/3 byte positions and leaves row 0 unchanged. It works on one row per clock under a level start/finish handshake. Its port set is identical to the forward step's, so benches and the round controller can drive either one unchanged.

## Interface
- No parameters.
- `clk`  input  1  — single clock; all state updates on rising edge.
- `rst`  input  1  — synchronous, active-high reset.
- `start`  input  1  — level request. Held high for the whole operation and until the result has been consumed.
- `in`  input  128  — state to transform. Byte i = `in[8i+7:8i]`. Row r, column c = byte r+4c.
- `key`  input  128  — round key. Present for step-interface uniformity and ignored. Must not affect any output.
- `finish`  output  1  — result valid; registered.
- `invshiftrowsstep`  output  128  — registered result. Byte r+4c = `in` byte r+4((c−r) mod 4).

## Operation
- State register `work[127:0]` holds the state being transformed.
- Row counter `row[1:0]` selects the row being processed.
- FSM states:
  - IDLE: `finish`=0. If `start`=1, capture `in` into `work`, set `row`←1, go to ROWS.
  - ROWS: right-rotate row `row` of `work` by `row` byte positions. All other rows are unchanged.
    - If `row`=3: load the rotated value into `invshiftrowsstep`, set `finish`←1, go to DONE.
    - Otherwise `row`←`row`+1.
    - If `start`=0 in ROWS: abort to IDLE. `work` is discarded, and `finish` and `invshiftrowsstep` are unchanged.
  - DONE: hold `finish`=1 and the output. When `start`=0, go to IDLE with `finish`←0 on that edge.
- `in` is sampled only on the IDLE→ROWS edge. Later changes to `in` have no effect on the running operation.
- While `start` stays high in DONE, the block does not restart. A new operation needs `start` low for at least one cycle.
- `invshiftrowsstep` holds its last result through IDLE and through an aborted run.

## Timing
- Reset values: `finish`=0, `invshiftrowsstep`=0, state IDLE, `row`=0, `work`=0.
- Latency: `start` sampled high at edge N gives `finish`=1 and a valid output after edge N+3 (4 rising edges including the capture edge).
- After `start` falls, `finish` falls after the next rising edge.
- `rst` has priority over every other event, including an edge where `finish` would rise.
- Reset mid-operation returns to IDLE with all outputs at their reset values.
- Simultaneous `start` fall and `row`=3 in ROWS: abort wins. `finish` stays 0 and the output is not updated.

## Configuration
- `INVSHIFTROWS_PARALLEL_EN` defined:
  - ROWS performs all three row rotations in a single cycle and goes straight to DONE.
  - Latency is 2 edges (capture, then result); `row` is unused.
  - All handshake, abort and reset rules are unchanged.
- Not defined: the row-serial behaviour above, with 4-edge latency.

## Test plan
- Raise `start` with `in`=128'h119fc17396be93e9e2173d2e2a7e406b and `key`=128'h3c4fcf098815f7aba6d2ae2816157e2b.
  - Required: `finish` rises 4 edges later (2 with the macro) and the output is 128'h2a179373117e3de9969f402ee2bec16b.
- Run back to back, dropping `start` between runs:
  - `in`=acac2d459c8aaf9e578eb71e516f03ae → 518eaf45ac6fb79e9cac031e578a2dae
  - `in`=19e4c81a111c0ae54652fba3efc15c30 → ef520a1a19c1fbe511e45ca3461cc830
  - `in`=7b9b9fe617246cad45372bdf10414ff6 → 10376ce67b412bad179b4fdf45249ff6
  - Required: `finish` low between runs.
- Change `in` and `key` on the cycle after capture.
  - Required: result still matches the captured value; `key` has no effect.
- Drop `start` during ROWS.
  - Required: `finish` stays 0, the output keeps its previous result, and the next full run is correct.
- Assert `rst` while in ROWS and while in DONE.
  - Required: `finish`=0 and output=0 on the next edge; a following run is correct.
- Hold `start` high in DONE for 10 cycles with a new `in`.
  - Required: `finish` stays 1, the output is unchanged, and no restart occurs.
